// File: rtl/fft_sequencer.sv
// rtl/fft_sequencer.sv - radix-2 DIT in-place FFT address and control sequencer
module fft_sequencer #(
    parameter int LOGN   = 10,
    parameter int BF_LAT = 0
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            Start,
    input  logic            Ack,
    input  logic            Stall,
    output logic [LOGN-1:0] i_top,
    output logic [LOGN-1:0] i_bot,
    output logic [LOGN-2:0] tw_idx,
    output logic            rd_en,
    output logic            wr_en,
    output logic [LOGN-1:0] wr_top,
    output logic [LOGN-1:0] wr_bot,
    output logic [3:0]      stage,
    output logic            Done,
    output logic [3:0]      state
);

    typedef enum logic [3:0] {
        S_INITIAL = 4'd0,
        S_DONE    = 4'd1,
        S_PROC    = 4'd2,
        S_GAP     = 4'd3
    } state_t;

    localparam logic [LOGN-2:0] B_LAST   = '1;
    localparam logic [LOGN-2:0] B_ONE    = (LOGN-1)'(1);
    localparam logic [LOGN-1:0] A_ONE    = LOGN'(1);
    localparam logic [3:0]      S_LAST   = 4'(LOGN - 1);
    localparam logic [2:0]      GAP_LAST = 3'(BF_LAT == 0 ? 0 : BF_LAT - 1);

    state_t          cur_state, state_n;
    logic [LOGN-2:0] b, b_n;
    logic [3:0]      s, s_n;
    logic [2:0]      gap_cnt, gap_n;
    logic [LOGN-1:0] top_h, bot_h;
    logic [LOGN-2:0] tw_h;

    logic [LOGN-1:0] bx, half, pos, top_c, bot_c;
    logic [LOGN-2:0] tw_c;

    // Address generation from butterfly counter b and stage s
    assign bx    = {1'b0, b};
    assign half  = A_ONE << s;
    assign pos   = bx & (half - A_ONE);
    assign top_c = ((bx >> s) << (s + 4'd1)) | pos;
    assign bot_c = top_c + half;
    assign tw_c  = pos[LOGN-2:0] << (S_LAST - s);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cur_state <= S_INITIAL;
            b         <= '0;
            s         <= '0;
            gap_cnt   <= '0;
            top_h     <= '0;
            bot_h     <= '0;
            tw_h      <= '0;
        end else begin
            cur_state <= state_n;
            b         <= b_n;
            s         <= s_n;
            gap_cnt   <= gap_n;
            if (cur_state == S_PROC) begin
                top_h <= top_c;
                bot_h <= bot_c;
                tw_h  <= tw_c;
            end
        end
    end

    always_comb begin
        state_n = cur_state;
        b_n     = b;
        s_n     = s;
        gap_n   = gap_cnt;
        case (cur_state)
            S_INITIAL: begin
                if (Start) begin
                    state_n = S_PROC;
                    b_n     = '0;
                    s_n     = '0;
                end
            end
            S_PROC: begin
                if (!Stall) begin
                    if (b == B_LAST) begin
                        b_n = '0;
                        if (BF_LAT != 0) begin
                            state_n = S_GAP;
                            gap_n   = '0;
                        end else if (s == S_LAST) begin
                            state_n = S_DONE;
                        end else begin
                            s_n = s + 4'd1;
                        end
                    end else begin
                        b_n = b + B_ONE;
                    end
                end
            end
            // Drain window: stage s write-backs land before stage s+1 reads
            S_GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    if (s == S_LAST) begin
                        state_n = S_DONE;
                    end else begin
                        state_n = S_PROC;
                        s_n     = s + 4'd1;
                    end
                end else begin
                    gap_n = gap_cnt + 3'd1;
                end
            end
            S_DONE: begin
                if (Ack) state_n = S_INITIAL;
            end
            default: state_n = S_INITIAL;
        endcase
    end

    assign rd_en  = (cur_state == S_PROC) && !Stall;
    assign i_top  = (cur_state == S_PROC) ? top_c : top_h;
    assign i_bot  = (cur_state == S_PROC) ? bot_c : bot_h;
    assign tw_idx = (cur_state == S_PROC) ? tw_c : tw_h;
    assign stage  = s;
    assign Done   = (cur_state == S_DONE);
    assign state  = cur_state;

    generate
        if (BF_LAT == 0) begin : g_nodly
            assign wr_en  = rd_en;
            assign wr_top = i_top;
            assign wr_bot = i_bot;
        end else begin : g_dly
            logic            en_q  [BF_LAT];
            logic [LOGN-1:0] top_q [BF_LAT];
            logic [LOGN-1:0] bot_q [BF_LAT];

            // Free-running: stalled cycles travel through as wr_en=0 bubbles
            always_ff @(posedge Clk) begin
                if (Reset) begin
                    for (int k = 0; k < BF_LAT; k++) begin
                        en_q[k]  <= 1'b0;
                        top_q[k] <= '0;
                        bot_q[k] <= '0;
                    end
                end else begin
                    en_q[0]  <= rd_en;
                    top_q[0] <= i_top;
                    bot_q[0] <= i_bot;
                    for (int k = 1; k < BF_LAT; k++) begin
                        en_q[k]  <= en_q[k-1];
                        top_q[k] <= top_q[k-1];
                        bot_q[k] <= bot_q[k-1];
                    end
                end
            end

            assign wr_en  = en_q[BF_LAT-1];
            assign wr_top = top_q[BF_LAT-1];
            assign wr_bot = bot_q[BF_LAT-1];
        end
    endgenerate

endmodule

// File: tb/tb_fft_sequencer.sv
// tb/tb_fft_sequencer.sv - scoreboard bench for fft_sequencer at three configurations
module tb_fft_sequencer;

    typedef struct {int id; int top; int bot; int tw;} ent_t;

    logic Clk = 1'b0;
    logic Reset;
    logic Start0, Ack0, Stall0, Start2, Ack2, Stall2, Start10, Ack10, Stall10;

    logic [2:0] it0, ib0, wt0, wb0;
    logic [1:0] tw0;
    logic       rd0, wr0, Done0;
    logic [3:0] stage0, state0;

    logic [2:0] it2, ib2, wt2, wb2;
    logic [1:0] tw2;
    logic       rd2, wr2, Done2;
    logic [3:0] stage2, state2;

    logic [9:0] it10, ib10, wt10, wb10;
    logic [8:0] tw10;
    logic       rd10, wr10, Done10;
    logic [3:0] stage10, state10;

    int checks = 0;
    int failures = 0;
    int cyc_n = 0;
    int t0 = 0;
    int gapc = 0;
    logic [1:0] h2 = 2'b00;
    logic mon_on = 1'b0;
    ent_t rdq[$];
    ent_t wrq[$];

    always #5 Clk = ~Clk;

    fft_sequencer #(.LOGN(3), .BF_LAT(0)) dut0 (
        .Clk(Clk), .Reset(Reset), .Start(Start0), .Ack(Ack0), .Stall(Stall0),
        .i_top(it0), .i_bot(ib0), .tw_idx(tw0), .rd_en(rd0), .wr_en(wr0),
        .wr_top(wt0), .wr_bot(wb0), .stage(stage0), .Done(Done0), .state(state0)
    );

    fft_sequencer #(.LOGN(3), .BF_LAT(2)) dut2 (
        .Clk(Clk), .Reset(Reset), .Start(Start2), .Ack(Ack2), .Stall(Stall2),
        .i_top(it2), .i_bot(ib2), .tw_idx(tw2), .rd_en(rd2), .wr_en(wr2),
        .wr_top(wt2), .wr_bot(wb2), .stage(stage2), .Done(Done2), .state(state2)
    );

    fft_sequencer #(.LOGN(10), .BF_LAT(0)) dut10 (
        .Clk(Clk), .Reset(Reset), .Start(Start10), .Ack(Ack10), .Stall(Stall10),
        .i_top(it10), .i_bot(ib10), .tw_idx(tw10), .rd_en(rd10), .wr_en(wr10),
        .wr_top(wt10), .wr_bot(wb10), .stage(stage10), .Done(Done10), .state(state10)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pack(input int id, input int a, input int b, input int c);
        return {16'(id), 16'(a), 16'(b), 16'(c)};
    endfunction

    // Reference order: groups of 2*half, k-th pair inside a group, twiddle k*N/(2*half)
    task automatic push_seq(input int id, input int logn);
        int n;
        int half;
        ent_t e;
        n = 1 << logn;
        for (int s = 0; s < logn; s++) begin
            half = 1 << s;
            for (int g = 0; g < n; g += 2 * half) begin
                for (int k = 0; k < half; k++) begin
                    e = '{id, g + k, g + k + half, k * (n / (2 * half))};
                    rdq.push_back(e);
                    wrq.push_back(e);
                end
            end
        end
    endtask

    task automatic chk_rd(input int id, input logic rd, input int top, input int bot, input int tw);
        ent_t e;
        if (rd === 1'b1) begin
            check($sformatf("rd%0d_expected", id), 64'(rdq.size() > 0), 64'd1);
            if (rdq.size() > 0) begin
                e = rdq.pop_front();
                check($sformatf("rd%0d_addr", id), pack(id, top, bot, tw), pack(e.id, e.top, e.bot, e.tw));
            end
        end
    endtask

    task automatic chk_wr(input int id, input logic wr, input int top, input int bot);
        ent_t e;
        if (wr === 1'b1) begin
            check($sformatf("wr%0d_expected", id), 64'(wrq.size() > 0), 64'd1);
            if (wrq.size() > 0) begin
                e = wrq.pop_front();
                check($sformatf("wr%0d_addr", id), pack(id, top, bot, 0), pack(e.id, e.top, e.bot, 0));
            end
        end
    endtask

    task automatic mon();
        if (mon_on) begin
            chk_rd(0, rd0, int'(it0), int'(ib0), int'(tw0));
            chk_rd(2, rd2, int'(it2), int'(ib2), int'(tw2));
            chk_rd(10, rd10, int'(it10), int'(ib10), int'(tw10));
            chk_wr(0, wr0, int'(wt0), int'(wb0));
            chk_wr(2, wr2, int'(wt2), int'(wb2));
            chk_wr(10, wr10, int'(wt10), int'(wb10));
            check("lag0", 64'(wr0), 64'(rd0));
            check("lag10", 64'(wr10), 64'(rd10));
            check("lag2", 64'(wr2), 64'(h2[1]));
            if (state2 == 4'd3) begin
                gapc++;
                check("gap_rd2", 64'(rd2), 64'd0);
            end
            if (Done2 === 1'b1) check("done_wr2", 64'(wr2), 64'd0);
        end
        h2 = Reset ? 2'b00 : {h2[0], rd2};
    endtask

    task automatic cyc();
        @(negedge Clk);
        mon();
        @(posedge Clk);
        #1;
        cyc_n++;
    endtask

    function automatic logic get_done(input int id);
        case (id)
            0:       return Done0;
            2:       return Done2;
            default: return Done10;
        endcase
    endfunction

    function automatic logic [3:0] get_state(input int id);
        case (id)
            0:       return state0;
            2:       return state2;
            default: return state10;
        endcase
    endfunction

    task automatic set_start(input int id, input logic v);
        case (id)
            0:       Start0 = v;
            2:       Start2 = v;
            default: Start10 = v;
        endcase
    endtask

    task automatic set_ack(input int id, input logic v);
        case (id)
            0:       Ack0 = v;
            2:       Ack2 = v;
            default: Ack10 = v;
        endcase
    endtask

    task automatic start(input int id, input int logn);
        push_seq(id, logn);
        set_start(id, 1'b1);
        cyc();
        set_start(id, 1'b0);
        t0 = cyc_n;
        check($sformatf("proc%0d_entered", id), 64'(get_state(id)), 64'd2);
    endtask

    task automatic wait_done(input int id, input int lim, input int exp_lat);
        int k;
        k = 0;
        while (get_done(id) !== 1'b1 && k < lim) begin
            cyc();
            k++;
        end
        check($sformatf("done%0d_reached", id), 64'(get_done(id)), 64'd1);
        check($sformatf("latency%0d", id), 64'(cyc_n - t0), 64'(exp_lat));
        check($sformatf("sb%0d_drained", id), 64'(rdq.size() + wrq.size()), 64'd0);
    endtask

    task automatic ack(input int id);
        set_ack(id, 1'b1);
        cyc();
        set_ack(id, 1'b0);
        check($sformatf("ack%0d_state", id), 64'(get_state(id)), 64'd0);
        check($sformatf("ack%0d_done", id), 64'(get_done(id)), 64'd0);
    endtask

    initial begin
        int k;
        Reset = 1'b1;
        {Start0, Ack0, Stall0, Start2, Ack2, Stall2, Start10, Ack10, Stall10} = '0;
        cyc();
        cyc();
        Reset = 1'b0;
        check("rst0", 64'({state0, stage0, it0, ib0, tw0, rd0, wr0, wt0, wb0, Done0}), 64'd0);
        check("rst2", 64'({state2, stage2, it2, ib2, tw2, rd2, wr2, wt2, wb2, Done2}), 64'd0);
        check("rst10", 64'({state10, stage10, it10, ib10, rd10, wr10, Done10}), 64'd0);
        mon_on = 1'b1;

        // Plain LOGN=3, BF_LAT=0 transform
        start(0, 3);
        wait_done(0, 40, 12);
        ack(0);

        // BF_LAT=2: two drain cycles after each stage
        gapc = 0;
        start(2, 3);
        wait_done(2, 60, 18);
        check("gap_cycles2", 64'(gapc), 64'd6);
        ack(2);

        // Stall for 3 cycles at stage 1, b=2
        start(0, 3);
        k = 0;
        while (!(stage0 == 4'd1 && it0 == 3'd4) && k < 20) begin
            cyc();
            k++;
        end
        check("stall_point", 64'({stage0, it0, ib0}), 64'({4'd1, 3'd4, 3'd6}));
        Stall0 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_hold", 64'({it0, ib0, rd0, wr0}), 64'({3'd4, 3'd6, 1'b0, 1'b0}));
            cyc();
        end
        Stall0 = 1'b0;
        #1;
        check("stall_resume", 64'({it0, ib0, rd0}), 64'({3'd4, 3'd6, 1'b1}));
        wait_done(0, 40, 15);
        ack(0);

        // Reset in the middle of stage 1, then a clean rerun
        start(0, 3);
        k = 0;
        while (stage0 != 4'd1 && k < 20) begin
            cyc();
            k++;
        end
        check("mid_stage1", 64'(stage0), 64'd1);
        cyc();
        Reset = 1'b1;
        cyc();
        Reset = 1'b0;
        check("rst_mid", 64'({state0, stage0, it0, ib0, tw0, rd0, wr0, wt0, wb0, Done0}), 64'd0);
        rdq.delete();
        wrq.delete();
        start(0, 3);
        check("rerun_first", 64'({stage0, it0, ib0, tw0}), 64'({4'd0, 3'd0, 3'd1, 2'd0}));
        wait_done(0, 40, 12);

        // Start held through DONE with Ack; Start pulse during PROC ignored
        Start0 = 1'b1;
        cyc();
        check("done_ignores_start", 64'(state0), 64'd1);
        Ack0 = 1'b1;
        cyc();
        Ack0 = 1'b0;
        check("ack_start_initial", 64'(state0), 64'd0);
        push_seq(0, 3);
        cyc();
        Start0 = 1'b0;
        t0 = cyc_n;
        check("restart_proc", 64'({state0, stage0, it0}), 64'({4'd2, 4'd0, 3'd0}));
        repeat (3) cyc();
        Start0 = 1'b1;
        cyc();
        Start0 = 1'b0;
        wait_done(0, 40, 12);
        ack(0);

        // Full-size LOGN=10 transform
        start(10, 10);
        wait_done(10, 6000, 5120);
        ack(10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
